// File: rtl/am_envelope_demod_pkg.sv
// Shared definitions for the AM envelope demodulator.
//   MID_SCALE : midscale reference; the AM modulator uses the same 2047 baseline
//   RECT_W    : width of the rectified magnitude (saturated to 2047)
//   state_e   : demodulator FSM state codes (WARMUP / RUN)
//   abs_diff  : |a - b| for unsigned 12-bit operands
package am_envelope_demod_pkg;

  localparam logic [11:0] MID_SCALE = 12'd2047;
  localparam int          RECT_W    = 11;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/am_envelope_demod_rectifier.sv
// Stage 1 of the envelope demodulator: full-wave rectification about MID.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   en         : demod enable; low suppresses sample capture and clears rect_v
//   adc_in     : 12-bit offset-binary sample
//   adc_valid  : adc_in qualifier
//   rect       : |adc_in - MID| saturated to 2047 (registered)
//   sat        : set when the raw magnitude was 2048 (registered with rect)
//   rect_v     : adc_valid && en delayed one cycle; qualifies rect/sat
module am_envelope_demod_rectifier
  import am_envelope_demod_pkg::*;
#(
  parameter logic [11:0] MID = MID_SCALE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [11:0]       adc_in,
  input  logic              adc_valid,
  output logic [RECT_W-1:0] rect,
  output logic              sat,
  output logic              rect_v
);

  logic [11:0] raw;
  logic        raw_sat;

  // Raw magnitude spans 0..2048; only 2048 exceeds the 11-bit range.
  assign raw     = abs_diff(adc_in, MID);
  assign raw_sat = (raw == 12'd2048);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rect   <= '0;
      sat    <= 1'b0;
      rect_v <= 1'b0;
    end else begin
      rect_v <= adc_valid && en;
      if (adc_valid && en) begin
        rect <= raw_sat ? {RECT_W{1'b1}} : raw[RECT_W-1:0];
        sat  <= raw_sat;
      end
    end
  end

endmodule

// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: rectify about midscale, integrate-and-dump over
// 2^LOG2_N valid samples, emit one 12-bit envelope sample per window.
// Build option: define AM_DEMOD_PEAK_EN to track the window maximum instead
// of the window mean (timing, FSM and clip behaviour unchanged).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en           : enable; low flushes the window and returns to WARMUP
//   adc_in       : 12-bit offset-binary ADC sample
//   adc_valid    : adc_in qualifier, one sample per high cycle
//   demod_out    : recovered envelope {value[10:0],1'b0}, held between pulses
//   demod_valid  : one-cycle pulse when demod_out updates
//   clip         : window contained a saturated sample; qualified by demod_valid
//   fsm_state    : current FSM state, for observation
// Handshake: adc_valid is a pure qualifier (no backpressure); demod_valid is a
// single-cycle strobe and demod_out/clip are stable from it until the next one.
module am_envelope_demod
  import am_envelope_demod_pkg::*;
#(
  parameter int          LOG2_N = 6,
  parameter logic [11:0] MID    = MID_SCALE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] adc_in,
  input  logic        adc_valid,
  output logic [11:0] demod_out,
  output logic        demod_valid,
  output logic        clip,
  output state_e      fsm_state
);

  localparam int ACC_W = RECT_W + LOG2_N;

  logic [RECT_W-1:0] rect;
  logic              sat;
  logic              rect_v;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [LOG2_N-1:0] cnt;
  logic              clip_acc;
  logic              win_end;
  logic [RECT_W-1:0] window_val;

  logic [RECT_W-1:0] mean_q;
  logic              clip_q;
  logic              pulse_q;

  state_e state_q, state_d;

  am_envelope_demod_rectifier #(.MID(MID)) u_rect (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .adc_in    (adc_in),
    .adc_valid (adc_valid),
    .rect      (rect),
    .sat       (sat),
    .rect_v    (rect_v)
  );

  assign win_end = rect_v && en && (cnt == {LOG2_N{1'b1}});

`ifdef AM_DEMOD_PEAK_EN
  // Running maximum held in the low bits of acc; upper bits stay zero.
  always_comb begin
    acc_next   = (ACC_W'(rect) > acc) ? ACC_W'(rect) : acc;
    window_val = acc_next[RECT_W-1:0];
  end
`else
  // The window sum includes the closing sample; >>LOG2_N leaves exactly RECT_W bits.
  always_comb begin
    acc_next   = acc + ACC_W'(rect);
    window_val = acc_next[ACC_W-1:LOG2_N];
  end
`endif

  // FSM: the first window after reset or enable only primes the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WARMUP;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en)          state_d = WARMUP;
    else if (win_end) state_d = RUN;
  end

  assign fsm_state = state_q;

  // Accumulate / dump, then a result register and the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      cnt         <= '0;
      clip_acc    <= 1'b0;
      mean_q      <= '0;
      clip_q      <= 1'b0;
      pulse_q     <= 1'b0;
      demod_out   <= '0;
      demod_valid <= 1'b0;
      clip        <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (!en) begin
        acc      <= '0;
        cnt      <= '0;
        clip_acc <= 1'b0;
      end else if (rect_v) begin
        if (win_end) begin
          acc      <= '0;
          cnt      <= '0;
          clip_acc <= 1'b0;
          if (state_q == RUN) begin
            mean_q  <= window_val;
            clip_q  <= clip_acc | sat;
            pulse_q <= 1'b1;
          end
        end else begin
          acc      <= acc_next;
          cnt      <= cnt + LOG2_N'(1);
          clip_acc <= clip_acc | sat;
        end
      end
      demod_valid <= pulse_q;
      if (pulse_q) begin
        demod_out <= {mean_q, 1'b0};
        clip      <= clip_q;
      end
    end
  end

endmodule

// File: tb/tb_am_envelope_demod.sv
module tb_am_envelope_demod;
  import am_envelope_demod_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] adc_in;
  logic        adc_valid;
  logic [11:0] demod_out;
  logic        demod_valid;
  logic        clip;
  state_e      fsm_state;

  int vectors;
  int miscompares;
  int cyc;
  int last_edge;

  // Observed pulses and expectations
  logic [11:0] pv_q[$];
  logic        pc_q[$];
  int          pt_q[$];
  logic [11:0] exp_q[$];
  logic        exp_clip_q[$];

  am_envelope_demod #(.LOG2_N(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .adc_in      (adc_in),
    .adc_valid   (adc_valid),
    .demod_out   (demod_out),
    .demod_valid (demod_valid),
    .clip        (clip),
    .fsm_state   (fsm_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (demod_valid) begin
      pv_q.push_back(demod_out);
      pc_q.push_back(clip);
      pt_q.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic send(input logic [11:0] d, input logic v);
    @(negedge clk);
    adc_in    = d;
    adc_valid = v;
    if (v) last_edge = cyc + 1;
  endtask

  task automatic feed_square(input int n);
    for (int i = 0; i < n; i++) send((i % 2 == 0) ? 12'd3047 : 12'd1047, 1'b1);
  endtask

  task automatic feed_const(input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(12'd2047, 1'b0);
  endtask

  task automatic clear_q;
    pv_q.delete();
    pc_q.delete();
    pt_q.delete();
    exp_q.delete();
    exp_clip_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; adc_in = 12'd2047; adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (demod_out !== 12'd0 || demod_valid !== 1'b0 || clip !== 1'b0 || fsm_state !== WARMUP) begin
      miscompares++;
      $display("FAIL reset_state: out=%0d valid=%0b clip=%0b state=%0d, required 0/0/0/0",
               demod_out, demod_valid, clip, fsm_state);
    end
    rst = 1'b1;
    clear_q();
    feed_square(128);
    idle(4);
    vectors++;
    if (pv_q.size() != 1 || pt_q[0] != last_edge + 2 || pv_q[0] !== 12'd2000) begin
      miscompares++;
      $display("FAIL first_run_pulse: count=%0d out=%0d cyc=%0d, required 1/2000/%0d",
               pv_q.size(), (pv_q.size() > 0) ? pv_q[0] : 12'd0, (pt_q.size() > 0) ? pt_q[0] : 0,
               last_edge + 2);
    end
    // Async reset mid-window
    feed_square(20);
    @(negedge clk);
    adc_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (demod_out !== 12'd0 || demod_valid !== 1'b0 || clip !== 1'b0 || fsm_state !== WARMUP) begin
      miscompares++;
      $display("FAIL async_reset: out=%0d valid=%0b clip=%0b state=%0d, required 0/0/0/0",
               demod_out, demod_valid, clip, fsm_state);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_q();
    feed_square(127);
    idle(4);
    vectors++;
    if (pv_q.size() != 0) begin
      miscompares++;
      $display("FAIL warmup_discard: pulses=%0d, required 0", pv_q.size());
    end
    feed_square(1);
    idle(4);
    vectors++;
    if (pv_q.size() != 1 || pt_q[0] != last_edge + 2 || pv_q[0] !== 12'd2000) begin
      miscompares++;
      $display("FAIL post_reset_pulse: count=%0d cyc=%0d, required 1 pulse of 2000 at %0d",
               pv_q.size(), (pt_q.size() > 0) ? pt_q[0] : 0, last_edge + 2);
    end
  endtask

  task automatic test_midscale;
    clear_q();
    feed_const(12'd2047, 128);
    idle(4);
    vectors++;
    if (pv_q.size() != 2) begin
      miscompares++;
      $display("FAIL midscale_count: pulses=%0d, required 2", pv_q.size());
    end else begin
      vectors++;
      if (pt_q[1] - pt_q[0] != 64 || pt_q[1] != last_edge + 2) begin
        miscompares++;
        $display("FAIL midscale_timing: spacing=%0d last=%0d, required 64/%0d",
                 pt_q[1] - pt_q[0], pt_q[1], last_edge + 2);
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (pv_q[i] !== 12'd0 || pc_q[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL midscale_value[%0d]: out=%0d clip=%0b, required 0/0", i, pv_q[i], pc_q[i]);
        end
      end
    end
  endtask

  task automatic test_square_and_clip;
    clear_q();
    feed_square(64);
    exp_q.push_back(12'd2000); exp_clip_q.push_back(1'b0);
    send(12'd4095, 1'b1);
    feed_const(12'd3047, 63);
`ifdef AM_DEMOD_PEAK_EN
    exp_q.push_back(12'd4094);
`else
    exp_q.push_back(12'd2032);
`endif
    exp_clip_q.push_back(1'b1);
    feed_square(64);
    exp_q.push_back(12'd2000); exp_clip_q.push_back(1'b0);
    idle(4);
    vectors++;
    if (pv_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL square_count: pulses=%0d, required %0d", pv_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < pv_q.size(); i++) begin
      vectors++;
      if (pv_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL square_value[%0d]: out=%0d, required %0d", i, pv_q[i], exp_q[i]);
      end
      vectors++;
      if (pc_q[i] !== exp_clip_q[i]) begin
        miscompares++;
        $display("FAIL square_clip[%0d]: clip=%0b, required %0b", i, pc_q[i], exp_clip_q[i]);
      end
    end
  endtask

  task automatic test_gapped_valid;
    clear_q();
    for (int i = 0; i < 128; i++) begin
      send((i % 2 == 0) ? 12'd3047 : 12'd1047, 1'b1);
      send(12'd0, 1'b0);
    end
    idle(4);
    vectors++;
    if (pv_q.size() != 2) begin
      miscompares++;
      $display("FAIL gapped_count: pulses=%0d, required 2", pv_q.size());
    end else begin
      vectors++;
      if (pt_q[1] - pt_q[0] != 128 || pv_q[0] !== 12'd2000 || pv_q[1] !== 12'd2000) begin
        miscompares++;
        $display("FAIL gapped_pulses: spacing=%0d out=%0d,%0d, required 128/2000,2000",
                 pt_q[1] - pt_q[0], pv_q[0], pv_q[1]);
      end
    end
  endtask

  task automatic test_enable;
    clear_q();
    feed_const(12'd2047, 30);
    @(negedge clk);
    en = 1'b0;
    adc_valid = 1'b0;
    idle(3);
    vectors++;
    if (pv_q.size() != 0 || demod_out !== 12'd2000 || fsm_state !== WARMUP) begin
      miscompares++;
      $display("FAIL enable_low: pulses=%0d out=%0d state=%0d, required 0/2000/0",
               pv_q.size(), demod_out, fsm_state);
    end
    en = 1'b1;
    feed_square(64);
    idle(4);
    vectors++;
    if (pv_q.size() != 0) begin
      miscompares++;
      $display("FAIL enable_discard: pulses=%0d, required 0", pv_q.size());
    end
    feed_square(64);
    idle(4);
    vectors++;
    if (pv_q.size() != 1 || pv_q[0] !== 12'd2000 || pt_q[0] != last_edge + 2) begin
      miscompares++;
      $display("FAIL enable_resume: pulses=%0d, required 1 pulse of 2000 at %0d",
               pv_q.size(), last_edge + 2);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_edge   = 0;
    test_reset();
    test_midscale();
    test_square_and_clip();
    test_gapped_valid();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
